// File: rtl/usb_rx_decoder_pkg.sv
// Shared types and constants for the USB receive decoder.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    EOP_WAIT = 2'd2
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [2:0] MAX_ONES  = 3'd6;

  // NRZI: an unchanged line level between samples encodes a 1.
  function automatic logic nrzi_bit(input logic level, input logic prev_level);
    return ~(level ^ prev_level);
  endfunction

endpackage

// File: rtl/usb_rx_decoder_if.sv
// Bundle of the USB line pair and decoded receive outputs.
interface usb_rx_if;
  logic       d_plus;
  logic       d_minus;
  logic       edge_detect;
  logic       shift_enable;
  logic       eop;
  logic [7:0] rcv_data;
  logic       byte_received;
  logic       stuff_err;

  modport master (
    output d_plus, d_minus,
    input  edge_detect, shift_enable, eop, rcv_data, byte_received, stuff_err
  );

  modport slave (
    input  d_plus, d_minus,
    output edge_detect, shift_enable, eop, rcv_data, byte_received, stuff_err
  );
endinterface

// File: rtl/usb_rx_decoder_sync2.sv
// Two-flop synchronizer for one asynchronous line, with a configurable reset level.
module usb_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two back-to-back flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RST_VAL;
      q_r    <= RST_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/usb_rx_decoder.sv
// USB full-speed receive path: synchronize, NRZI-decode, unstuff and assemble bytes.
module usb_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic       edge_detect,
  output logic       shift_enable,
  output logic       eop,
  output logic [7:0] rcv_data,
  output logic       byte_received,
  output logic       stuff_err
);

  localparam int            TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_SAMPLE = TW'(SAMPLE_PT);

  logic          dp_s;
  logic          dm_s;
  logic          dp_prev_r;
  rx_state_e     state_r,    state_nx;
  logic [TW-1:0] timer_r,    timer_nx;
  logic [2:0]    ones_r,     ones_nx;
  logic [2:0]    bitcnt_r,   bitcnt_nx;
  logic [7:0]    shreg_r,    shreg_nx;
  logic          last_r,     last_nx;
  logic [7:0]    rcv_data_r, rcv_data_nx;
  logic          byte_rcv_r, byte_rcv_nx;
  logic          stuff_err_r, stuff_err_nx;
  logic          edge_s;
  logic          sample_s;
  logic          bit_s;
  logic          eop_s;

  usb_sync2 #(.RST_VAL(1'b1)) u_sync_dp (.clk(clk), .rst(rst), .d(d_plus),  .q(dp_s));
  usb_sync2 #(.RST_VAL(1'b0)) u_sync_dm (.clk(clk), .rst(rst), .d(d_minus), .q(dm_s));

  assign edge_s   = dp_s ^ dp_prev_r;
  assign eop_s    = ~dp_s & ~dm_s;
  assign sample_s = (state_r != IDLE) && (timer_r == T_SAMPLE);
  assign bit_s    = nrzi_bit(dp_s, last_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Bit timer, unstuffing counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_prev_r   <= 1'b1;
      timer_r     <= {TW{1'b0}};
      ones_r      <= 3'd0;
      bitcnt_r    <= 3'd0;
      shreg_r     <= 8'h00;
      last_r      <= 1'b1;
      rcv_data_r  <= 8'h00;
      byte_rcv_r  <= 1'b0;
      stuff_err_r <= 1'b0;
    end else begin
      dp_prev_r   <= dp_s;
      timer_r     <= timer_nx;
      ones_r      <= ones_nx;
      bitcnt_r    <= bitcnt_nx;
      shreg_r     <= shreg_nx;
      last_r      <= last_nx;
      rcv_data_r  <= rcv_data_nx;
      byte_rcv_r  <= byte_rcv_nx;
      stuff_err_r <= stuff_err_nx;
    end
  end

  // Next-state and datapath decisions for each receive phase.
  always_comb begin
    state_nx     = state_r;
    ones_nx      = ones_r;
    bitcnt_nx    = bitcnt_r;
    shreg_nx     = shreg_r;
    last_nx      = last_r;
    rcv_data_nx  = rcv_data_r;
    byte_rcv_nx  = 1'b0;
    stuff_err_nx = 1'b0;

    case (state_r)
      IDLE: begin
        if (edge_s) begin
          state_nx  = ACTIVE;
          ones_nx   = 3'd0;
          bitcnt_nx = 3'd0;
          last_nx   = dp_prev_r;
        end else begin
          state_nx  = IDLE;
        end
      end
      ACTIVE: begin
        if (sample_s) begin
          last_nx = dp_s;
          if (eop_s) begin
            // SE0 ends the packet; a partially assembled byte is dropped.
            state_nx  = EOP_WAIT;
            ones_nx   = 3'd0;
            bitcnt_nx = 3'd0;
          end else if (ones_r == MAX_ONES) begin
            ones_nx      = 3'd0;
            stuff_err_nx = bit_s;
          end else begin
            shreg_nx = {bit_s, shreg_r[7:1]};
            ones_nx  = bit_s ? (ones_r + 3'd1) : 3'd0;
            if (bitcnt_r == 3'd7) begin
              rcv_data_nx = {bit_s, shreg_r[7:1]};
              byte_rcv_nx = 1'b1;
              bitcnt_nx   = 3'd0;
            end else begin
              bitcnt_nx   = bitcnt_r + 3'd1;
            end
          end
        end else begin
          state_nx = ACTIVE;
        end
      end
      EOP_WAIT: begin
        if (sample_s) begin
          last_nx = dp_s;
          if (dp_s && !dm_s) begin
            state_nx = IDLE;
          end else begin
            state_nx = EOP_WAIT;
          end
        end else begin
          state_nx = EOP_WAIT;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Bit timer: parked in IDLE, resynchronized on every line transition.
  always_comb begin
    timer_nx = timer_r;
    if (state_r == IDLE || edge_s) begin
      timer_nx = {TW{1'b0}};
    end else if (timer_r == T_LAST) begin
      timer_nx = {TW{1'b0}};
    end else begin
      timer_nx = timer_r + TW'(1);
    end
  end

  assign edge_detect   = edge_s;
  assign shift_enable  = sample_s;
  assign eop           = eop_s;
  assign rcv_data      = rcv_data_r;
  assign byte_received = byte_rcv_r;
  assign stuff_err     = stuff_err_r;

endmodule
